// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Module  : mem_arbiter_pkg                                                  |
// | Purpose : Shared types and constants for the unified-memory arbiter:       |
// |           default bus widths, FSM state encoding, transaction owner        |
// |           encoding and the arbitration decision function.                  |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
//------------------------------------------------------------------------------
package mem_arbiter_pkg;

   // Default bus widths of the core.
   localparam int ARB_ADDR_WIDTH = 32;
   localparam int ARB_DATA_WIDTH = 32;

   // Arbiter FSM state encoding (2 bits).
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_WAIT = 2'd2
   } arb_state_e;

   // Owner of the single outstanding transaction.
   typedef enum logic {
      ARB_OWN_I = 1'b0,
      ARB_OWN_D = 1'b1
   } arb_owner_e;

   // D has priority unless I is also waiting and D has already used up its
   // allowed streak of back-to-back grants.
   function automatic arb_owner_e arb_pick(input logic if_req,
                                           input logic d_req,
                                           input logic streak_full);
      arb_owner_e own;
      if (d_req && !(if_req && streak_full)) begin
         own = ARB_OWN_D;
      end else begin
         own = ARB_OWN_I;
      end
      return own;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Module  : mem_arbiter                                                      |
// | Purpose : Shares one single-port unified memory between instruction fetch  |
// |           (I-port) and the MEM stage (D-port). One outstanding transaction |
// |           at a time, D priority with a bounded-streak fairness rule, stall |
// |           requests towards pipe_ctrl and discard of flushed fetch data.    |
// | Ports   : clk_i, rst_i (async, active-high)                                |
// |           I-port : if_req_i, if_addr_i -> if_gnt_o, if_rvalid_o,           |
// |                    if_rdata_o, if_stallreq_o                               |
// |           D-port : d_req_i, d_we_i, d_addr_i, d_wdata_i -> d_gnt_o,        |
// |                    d_rvalid_o, d_rdata_o, d_stallreq_o                     |
// |           Ctrl   : flush_i (jump flush)                                    |
// |           Memory : mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o <-         |
// |                    mem_gnt_i, mem_rvalid_i, mem_rdata_i                    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = ARB_ADDR_WIDTH,
   parameter int DATA_WIDTH   = ARB_DATA_WIDTH,
   parameter int MAX_D_STREAK = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // instruction-fetch port
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic                  if_gnt_o,
   output logic                  if_rvalid_o,
   output logic [DATA_WIDTH-1:0] if_rdata_o,
   output logic                  if_stallreq_o,
   // data port
   input  logic                  d_req_i,
   input  logic                  d_we_i,
   input  logic [ADDR_WIDTH-1:0] d_addr_i,
   input  logic [DATA_WIDTH-1:0] d_wdata_i,
   output logic                  d_gnt_o,
   output logic                  d_rvalid_o,
   output logic [DATA_WIDTH-1:0] d_rdata_o,
   output logic                  d_stallreq_o,
   // pipeline control
   input  logic                  flush_i,
   // memory side
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

   // FSM and transaction context
   arb_state_e              state_q,  state_d;
   arb_owner_e              owner_q,  owner_d;
   logic [ADDR_WIDTH-1:0]   addr_q,   addr_d;
   logic                    we_q,     we_d;
   logic [DATA_WIDTH-1:0]   wdata_q,  wdata_d;
   logic [STREAK_W-1:0]     streak_q, streak_d;
   logic                    discard_q, discard_d;

   // registered port outputs
   logic                    if_gnt_q,    if_gnt_d;
   logic                    d_gnt_q,     d_gnt_d;
   logic                    if_rvalid_q, if_rvalid_d;
   logic                    d_rvalid_q,  d_rvalid_d;
   logic [DATA_WIDTH-1:0]   if_rdata_q,  if_rdata_d;
   logic [DATA_WIDTH-1:0]   d_rdata_q,   d_rdata_d;

   logic                    streak_full;
   arb_owner_e              win_own;
   logic                    busy_i;
   logic                    busy_d;

   assign streak_full = (streak_q == STREAK_W'(MAX_D_STREAK));
   assign win_own     = arb_pick(if_req_i, d_req_i, streak_full);

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ARB_IDLE;
         owner_q     <= ARB_OWN_I;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         streak_q    <= '0;
         discard_q   <= 1'b0;
         if_gnt_q    <= 1'b0;
         d_gnt_q     <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         streak_q    <= streak_d;
         discard_q   <= discard_d;
         if_gnt_q    <= if_gnt_d;
         d_gnt_q     <= d_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      streak_d    = streak_q;
      discard_d   = discard_q;
      if_gnt_d    = 1'b0;
      d_gnt_d     = 1'b0;
      if_rvalid_d = 1'b0;
      d_rvalid_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;

      case (state_q)
         ARB_IDLE: begin
            // flush_i is deliberately ignored here: nothing is in flight.
            if (if_req_i || d_req_i) begin
               state_d   = ARB_REQ;
               owner_d   = win_own;
               discard_d = 1'b0;
               if (win_own == ARB_OWN_D) begin
                  addr_d  = d_addr_i;
                  we_d    = d_we_i;
                  wdata_d = d_wdata_i;
                  d_gnt_d = 1'b1;
                  // The streak only counts D grants that made a waiting
                  // fetch wait longer.
                  if (if_req_i) begin
                     streak_d = streak_full ? streak_q : streak_q + 1'b1;
                  end else begin
                     streak_d = '0;
                  end
               end else begin
                  addr_d   = if_addr_i;
                  we_d     = 1'b0;
                  wdata_d  = '0;
                  if_gnt_d = 1'b1;
                  streak_d = '0;
               end
            end
         end

         ARB_REQ: begin
            if (flush_i && (owner_q == ARB_OWN_I)) begin
               discard_d = 1'b1;
            end
            if (mem_gnt_i) begin
               state_d = ARB_WAIT;
            end
         end

         ARB_WAIT: begin
            if (mem_rvalid_i) begin
               state_d   = ARB_IDLE;
               discard_d = 1'b0;
               if (owner_q == ARB_OWN_D) begin
                  d_rvalid_d = 1'b1;
                  d_rdata_d  = we_q ? '0 : mem_rdata_i;
               end else if (!discard_q && !flush_i) begin
                  // A flush arriving together with the response also kills it.
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = mem_rdata_i;
               end
            end else if (flush_i && (owner_q == ARB_OWN_I)) begin
               discard_d = 1'b1;
            end
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign busy_i = (state_q != ARB_IDLE) && (owner_q == ARB_OWN_I);
   assign busy_d = (state_q != ARB_IDLE) && (owner_q == ARB_OWN_D);

   // Gated by rst_i so that every output reads 0 while reset is held, even
   // with a requester still asserting its request.
   assign if_stallreq_o = ~rst_i & ((if_req_i & ~if_rvalid_q) | busy_i);
   assign d_stallreq_o  = ~rst_i & ((d_req_i  & ~d_rvalid_q)  | busy_d);

   assign if_gnt_o    = if_gnt_q;
   assign if_rvalid_o = if_rvalid_q;
   assign if_rdata_o  = if_rdata_q;
   assign d_gnt_o     = d_gnt_q;
   assign d_rvalid_o  = d_rvalid_q;
   assign d_rdata_o   = d_rdata_q;

   assign mem_req_o   = (state_q == ARB_REQ);
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Module  : tb_mem_arbiter                                                   |
// | Purpose : Self-checking bench for mem_arbiter: directed scenarios plus a   |
// |           randomized run against a transaction-level reference model.      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXS = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, d_req, d_we, flush;
   logic [AW-1:0] if_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic          mem_gnt, mem_rvalid;
   logic [DW-1:0] mem_rdata;

   logic          if_gnt_o, if_rvalid_o, if_stallreq_o;
   logic [DW-1:0] if_rdata_o;
   logic          d_gnt_o, d_rvalid_o, d_stallreq_o;
   logic [DW-1:0] d_rdata_o;
   logic          mem_req_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;

   logic [135:0]  all_outs;
   assign all_outs = {if_gnt_o, if_rvalid_o, if_rdata_o, if_stallreq_o,
                      d_gnt_o, d_rvalid_o, d_rdata_o, d_stallreq_o,
                      mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_D_STREAK(MAXS)) dut (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_stallreq_o(if_stallreq_o),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
      .d_stallreq_o(d_stallreq_o), .flush_i(flush),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
      .mem_rdata_i(mem_rdata)
   );

   task automatic idle_inputs();
      if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      flush = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk); rst = 1; idle_inputs();
      @(negedge clk); @(negedge clk); rst = 0;
   endtask

   task automatic test_reset();
      rst = 1; idle_inputs(); if_req = 1; d_req = 1; flush = 1;
      repeat (2) @(negedge clk);
      checks++; if (all_outs !== '0) begin errors++; $display("FAIL reset_held_outputs: got %h want 0", all_outs); end
      if_req = 0; d_req = 0; flush = 0;
      @(negedge clk); rst = 0;
      @(negedge clk);
      checks++; if (all_outs !== '0) begin errors++; $display("FAIL reset_idle_outputs: got %h want 0", all_outs); end
   endtask

   task automatic test_lone_fetch();
      @(negedge clk); if_req = 1; if_addr = 32'h100;
      #1;
      checks++; if (if_stallreq_o !== 1'b1) begin errors++; $display("FAIL fetch_stall_pending: got %b want 1", if_stallreq_o); end
      @(negedge clk); // cycle 1
      checks++; if ({if_gnt_o, d_gnt_o} !== 2'b10) begin errors++; $display("FAIL fetch_gnt: got %b want 10", {if_gnt_o, d_gnt_o}); end
      checks++; if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, 32'h100}) begin errors++; $display("FAIL fetch_mem_req: got %h want %h", {mem_req_o, mem_we_o, mem_addr_o}, {1'b1, 1'b0, 32'h100}); end
      if_req = 0; mem_gnt = 1;
      @(negedge clk); // cycle 2
      checks++; if ({mem_req_o, if_gnt_o, if_stallreq_o} !== 3'b001) begin errors++; $display("FAIL fetch_wait_state: got %b want 001", {mem_req_o, if_gnt_o, if_stallreq_o}); end
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
      @(negedge clk); // cycle 3
      mem_rvalid = 0; mem_rdata = 32'h0BADF00D;
      checks++; if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL fetch_rdata: got %h want %h", {if_rvalid_o, if_rdata_o}, {1'b1, 32'hDEADBEEF}); end
      checks++; if ({if_stallreq_o, d_rvalid_o} !== 2'b00) begin errors++; $display("FAIL fetch_done_stall: got %b want 00", {if_stallreq_o, d_rvalid_o}); end
      @(negedge clk);
      checks++; if ({if_rvalid_o, if_rdata_o} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL fetch_rdata_hold: got %h want %h", {if_rvalid_o, if_rdata_o}, {1'b0, 32'hDEADBEEF}); end
   endtask

   task automatic test_fairness();
      string got = "";
      string want = "DDDDIDDDDI";
      int    n = 0;
      bit    rsp_due = 0;
      apply_reset();
      @(negedge clk); if_req = 1; d_req = 1; if_addr = 32'h40; d_addr = 32'h80;
      for (int cyc = 0; cyc < 200 && n < 10; cyc++) begin
         @(negedge clk);
         if (if_gnt_o && d_gnt_o) begin
            checks++; errors++; $display("FAIL fair_double_gnt: got both grants want one");
         end
         if (d_gnt_o) begin got = {got, "D"}; n++; end
         if (if_gnt_o) begin got = {got, "I"}; n++; end
         mem_rvalid = rsp_due; rsp_due = 0;
         if (mem_gnt) rsp_due = 1;
         mem_gnt = mem_req_o;
      end
      checks++; if (got != want) begin errors++; $display("FAIL fair_order: got %s want %s", got, want); end
      idle_inputs();
   endtask

   task automatic test_write_stall();
      apply_reset();
      @(negedge clk); d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h55AA;
      @(negedge clk); // cycle 1
      checks++; if (d_gnt_o !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", d_gnt_o); end
      d_req = 0; d_we = 0; d_addr = 32'hFFFF; d_wdata = 32'h1234;
      for (int k = 0; k < 4; k++) begin
         checks++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 32'h2000, 32'h55AA}) begin errors++; $display("FAIL wr_hold_%0d: got %h want %h", k, {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, {1'b1, 1'b1, 32'h2000, 32'h55AA}); end
         checks++; if (d_stallreq_o !== 1'b1) begin errors++; $display("FAIL wr_stall_%0d: got %b want 1", k, d_stallreq_o); end
         if (k == 3) mem_gnt = 1;
         @(negedge clk);
      end
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE0001;
      @(negedge clk);
      mem_rvalid = 0;
      checks++; if ({d_rvalid_o, d_rdata_o, if_rvalid_o} !== {1'b1, 32'h0, 1'b0}) begin errors++; $display("FAIL wr_ack: got %h want %h", {d_rvalid_o, d_rdata_o, if_rvalid_o}, {1'b1, 32'h0, 1'b0}); end
      @(negedge clk);
      checks++; if ({d_rvalid_o, d_stallreq_o} !== 2'b00) begin errors++; $display("FAIL wr_after: got %b want 00", {d_rvalid_o, d_stallreq_o}); end
   endtask

   task automatic test_flush();
      apply_reset();
      @(negedge clk); if_req = 1; if_addr = 32'h300;
      @(negedge clk); if_req = 0; mem_gnt = 1;
      @(negedge clk); mem_gnt = 0; flush = 1; d_req = 1; d_we = 0; d_addr = 32'h40;
      @(negedge clk); flush = 0;
      checks++; if ({d_gnt_o, if_stallreq_o, d_stallreq_o} !== 3'b011) begin errors++; $display("FAIL flush_wait1: got %b want 011", {d_gnt_o, if_stallreq_o, d_stallreq_o}); end
      @(negedge clk); mem_rvalid = 1; mem_rdata = 32'h11112222;
      checks++; if (d_gnt_o !== 1'b0) begin errors++; $display("FAIL flush_wait2: got %b want 0", d_gnt_o); end
      @(negedge clk); mem_rvalid = 0;
      checks++; if ({if_rvalid_o, d_gnt_o, if_stallreq_o} !== 3'b000) begin errors++; $display("FAIL flush_suppress: got %b want 000", {if_rvalid_o, d_gnt_o, if_stallreq_o}); end
      @(negedge clk);
      checks++; if (d_gnt_o !== 1'b1) begin errors++; $display("FAIL flush_d_gnt: got %b want 1", d_gnt_o); end
      d_req = 0; mem_gnt = 1;
      @(negedge clk); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h33334444;
      @(negedge clk); mem_rvalid = 0;
      checks++; if ({d_rvalid_o, d_rdata_o} !== {1'b1, 32'h33334444}) begin errors++; $display("FAIL flush_d_rdata: got %h want %h", {d_rvalid_o, d_rdata_o}, {1'b1, 32'h33334444}); end
      // flush in the same cycle as the response
      if_req = 1; if_addr = 32'h304;
      @(negedge clk); if_req = 0; mem_gnt = 1;
      @(negedge clk); mem_gnt = 0; flush = 1; mem_rvalid = 1; mem_rdata = 32'h55556666;
      @(negedge clk); flush = 0; mem_rvalid = 0;
      checks++; if (if_rvalid_o !== 1'b0) begin errors++; $display("FAIL flush_same_cycle: got %b want 0", if_rvalid_o); end
      // flush while idle has no effect, and the discard state is gone
      if_req = 1; if_addr = 32'h308; flush = 1;
      @(negedge clk); flush = 0;
      checks++; if (if_gnt_o !== 1'b1) begin errors++; $display("FAIL flush_idle_gnt: got %b want 1", if_gnt_o); end
      if_req = 0; mem_gnt = 1;
      @(negedge clk); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h77778888;
      @(negedge clk); mem_rvalid = 0;
      checks++; if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'h77778888}) begin errors++; $display("FAIL flush_next_fetch: got %h want %h", {if_rvalid_o, if_rdata_o}, {1'b1, 32'h77778888}); end
   endtask

   task automatic test_reset_mid_wait();
      apply_reset();
      @(negedge clk); d_req = 1; d_we = 0; d_addr = 32'h80;
      @(negedge clk); d_req = 0; mem_gnt = 1;
      @(negedge clk); mem_gnt = 0;
      #2 rst = 1;
      #1;
      checks++; if (all_outs !== '0) begin errors++; $display("FAIL async_reset_outputs: got %h want 0", all_outs); end
      @(negedge clk); rst = 0;
      @(negedge clk); mem_rvalid = 1; mem_rdata = 32'h99999999;
      @(negedge clk); mem_rvalid = 0;
      checks++; if (all_outs !== '0) begin errors++; $display("FAIL late_rvalid_ignored: got %h want 0", all_outs); end
   endtask

   task automatic test_spurious();
      apply_reset();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         mem_rvalid = (k % 2 == 0); mem_gnt = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
         @(negedge clk);
         mem_rvalid = 0; mem_gnt = 0;
         checks++; if (all_outs !== '0) begin errors++; $display("FAIL spurious_%0d: got %h want 0", k, all_outs); end
      end
      if_req = 1; if_addr = 32'h500;
      @(negedge clk);
      checks++; if ({if_gnt_o, mem_req_o, mem_addr_o} !== {2'b11, 32'h500}) begin errors++; $display("FAIL spurious_then_fetch: got %h want %h", {if_gnt_o, mem_req_o, mem_addr_o}, {2'b11, 32'h500}); end
      if_req = 0;
   endtask

   // Randomized traffic; the model tracks transactions, the streak rule and
   // memory contents as seen from the requester side, while the responder
   // keeps its own memory image driven only by the mem_* bus.
   task automatic test_random();
      logic [31:0] model_mem [16];
      logic [31:0] phys_mem  [16];
      int          streak = 0;
      bit          busy = 0, gnt_exp = 0, gnt_exp_d = 0;
      bit          rsp_exp = 0, rsp_exp_d = 0, inflight = 0, inflight_d = 0;
      logic [31:0] rsp_exp_data = '0, cur_data = '0, mem_rd_cap = '0;
      bit          cur_d = 0, mem_pend = 0, mem_we_cap = 0;
      int          mem_delay = 0;
      bit          p_gi, p_gd, e_irv, e_drv, e_is, e_ds, win_d;
      logic [31:0] got_data;
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         model_mem[i] = 32'hA0000000 | i;
         phys_mem[i]  = 32'hA0000000 | i;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         p_gi = gnt_exp && !gnt_exp_d; p_gd = gnt_exp && gnt_exp_d;
         e_irv = rsp_exp && !rsp_exp_d; e_drv = rsp_exp && rsp_exp_d;
         if (gnt_exp) begin inflight = 1; inflight_d = gnt_exp_d; end
         if (rsp_exp) begin inflight = 0; busy = 0; end
         e_is = (if_req && !e_irv) || (inflight && !inflight_d);
         e_ds = (d_req && !e_drv) || (inflight && inflight_d);
         checks++; if ({if_gnt_o, d_gnt_o} !== {p_gi, p_gd}) begin errors++; $display("FAIL rnd_gnt cyc %0d: got %b want %b", cyc, {if_gnt_o, d_gnt_o}, {p_gi, p_gd}); end
         checks++; if ({if_rvalid_o, d_rvalid_o} !== {e_irv, e_drv}) begin errors++; $display("FAIL rnd_rvalid cyc %0d: got %b want %b", cyc, {if_rvalid_o, d_rvalid_o}, {e_irv, e_drv}); end
         if (rsp_exp) begin
            got_data = rsp_exp_d ? d_rdata_o : if_rdata_o;
            checks++; if (got_data !== rsp_exp_data) begin errors++; $display("FAIL rnd_rdata cyc %0d: got %h want %h", cyc, got_data, rsp_exp_data); end
         end
         checks++; if ({if_stallreq_o, d_stallreq_o} !== {e_is, e_ds}) begin errors++; $display("FAIL rnd_stall cyc %0d: got %b want %b", cyc, {if_stallreq_o, d_stallreq_o}, {e_is, e_ds}); end
         gnt_exp = 0; rsp_exp = 0;
         // memory responder
         mem_rvalid = 0; mem_rdata = $urandom;
         if (mem_pend) begin
            mem_delay--;
            if (mem_delay == 0) begin
               mem_rvalid = 1; mem_pend = 0;
               if (!mem_we_cap) mem_rdata = mem_rd_cap;
               rsp_exp = 1; rsp_exp_d = cur_d; rsp_exp_data = cur_data;
            end
         end else if ($urandom_range(0, 7) == 0) begin
            mem_rvalid = 1; // spurious, nothing outstanding
         end
         mem_gnt = 0;
         if (mem_req_o && $urandom_range(0, 2) != 0) begin
            mem_gnt = 1; mem_pend = 1; mem_delay = int'($urandom_range(1, 3)); mem_we_cap = mem_we_o;
            if (mem_we_o) phys_mem[mem_addr_o[5:2]] = mem_wdata_o;
            else          mem_rd_cap = phys_mem[mem_addr_o[5:2]];
         end
         // requesters
         if (p_gi) if_req = 0;
         else if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1; if_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         end
         if (p_gd) d_req = 0;
         else if (!d_req && $urandom_range(0, 1) == 0) begin
            d_req = 1; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
            d_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         end
         // reference arbitration
         if (!busy && (if_req || d_req)) begin
            win_d = d_req && !(if_req && streak == MAXS);
            if (win_d) streak = if_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
            else       streak = 0;
            busy = 1; gnt_exp = 1; gnt_exp_d = win_d; cur_d = win_d;
            if (win_d) begin
               if (d_we) begin model_mem[d_addr[5:2]] = d_wdata; cur_data = '0; end
               else cur_data = model_mem[d_addr[5:2]];
            end else begin
               cur_data = model_mem[if_addr[5:2]];
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      test_reset();
      test_lone_fetch();
      test_fairness();
      test_write_stall();
      test_flush();
      test_reset_mid_wait();
      test_spurious();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
